// File: rtl/key_debounce_multi.sv
// N-channel key debouncer: shared 1 ms timebase, per-key 2-FF synchroniser and
// debounce FSM producing a level plus press/release/long/repeat pulses.
module key_debounce_multi #(
   parameter int unsigned N_KEYS      = 4,
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned DEBOUNCE_MS = 10,
   parameter int unsigned LONG_MS     = 1000,
   parameter int unsigned REPEAT_MS   = 200,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [N_KEYS-1:0] pin_in,
   output logic [N_KEYS-1:0] key_state,
   output logic [N_KEYS-1:0] press_pulse,
   output logic [N_KEYS-1:0] release_pulse,
   output logic [N_KEYS-1:0] long_pulse,
   output logic [N_KEYS-1:0] repeat_pulse
);

   localparam int unsigned TickDiv = CLK_FREQ_HZ / 1000;
   localparam int unsigned PreW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;
   localparam int unsigned MaxDl   = (DEBOUNCE_MS > LONG_MS) ? DEBOUNCE_MS : LONG_MS;
   localparam int unsigned MaxMs   = (MaxDl > REPEAT_MS) ? MaxDl : REPEAT_MS;
   localparam int unsigned CntW    = $clog2(MaxMs + 1);
   localparam bit          RepEn   = (REPEAT_MS > 0);

   localparam logic [PreW-1:0] PreLast  = PreW'(TickDiv - 1);
   // Each window completes on the tick that would take the count to M.
   localparam logic [CntW-1:0] DbLast   = CntW'(DEBOUNCE_MS - 1);
   localparam logic [CntW-1:0] HeldLast = CntW'(LONG_MS - DEBOUNCE_MS - 1);
   localparam logic [CntW-1:0] RepLast  = CntW'((REPEAT_MS > 0) ? (REPEAT_MS - 1) : 0);
   localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};

   typedef enum logic [2:0] {
      StIdle,
      StPressDb,
      StHeld,
      StLong,
      StRelDb
   } state_e;

   logic [PreW-1:0]   pre_q, pre_d;
   logic              tick;
   logic [N_KEYS-1:0] sync1_q, sync2_q;
   logic [N_KEYS-1:0] act;

   assign tick = (pre_q == PreLast);

   // Free-running millisecond prescaler, never restarted by key activity.
   always_comb begin
      pre_d = tick ? '0 : pre_q + 1'b1;
   end

   // Prescaler register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   // Two-stage synchroniser, reset to the released pin level.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= {N_KEYS{ACTIVE_LOW}};
         sync2_q <= {N_KEYS{ACTIVE_LOW}};
      end else begin
         sync1_q <= pin_in;
         sync2_q <= sync1_q;
      end
   end

   assign act = ACTIVE_LOW ? ~sync2_q : sync2_q;

   for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
      state_e            state_q, state_d;
      logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
      logic              was_long_q, was_long_d;
      logic              key_q, key_d;
      logic              press_q, press_d;
      logic              rel_q, rel_d;
      logic              long_q, long_d;
      logic              rep_q, rep_d;

      // Next state and registered outputs; a change of act always beats a
      // window completing in the same cycle.
      always_comb begin
         cnt_inc    = (tick && (cnt_q != CntMax)) ? cnt_q + 1'b1 : cnt_q;
         state_d    = state_q;
         cnt_d      = cnt_inc;
         was_long_d = was_long_q;
         key_d      = key_q;
         press_d    = 1'b0;
         rel_d      = 1'b0;
         long_d     = 1'b0;
         rep_d      = 1'b0;
         case (state_q)
            StIdle: begin
               cnt_d = '0;
               if (act[gi]) begin
                  state_d = StPressDb;
               end
            end
            StPressDb: begin
               if (!act[gi]) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else if (tick && (cnt_q == DbLast)) begin
                  state_d = StHeld;
                  cnt_d   = '0;
                  key_d   = 1'b1;
                  press_d = 1'b1;
               end
            end
            StHeld: begin
               if (!act[gi]) begin
                  state_d = StRelDb;
                  cnt_d   = '0;
               end else if (tick && (cnt_q == HeldLast)) begin
                  state_d    = StLong;
                  cnt_d      = '0;
                  was_long_d = 1'b1;
                  long_d     = 1'b1;
               end
            end
            StLong: begin
               if (!act[gi]) begin
                  state_d = StRelDb;
                  cnt_d   = '0;
               end else if (RepEn && tick && (cnt_q == RepLast)) begin
                  cnt_d = '0;
                  rep_d = 1'b1;
               end
            end
            StRelDb: begin
               if (act[gi]) begin
                  state_d = was_long_q ? StLong : StHeld;
                  cnt_d   = '0;
               end else if (tick && (cnt_q == DbLast)) begin
                  state_d    = StIdle;
                  cnt_d      = '0;
                  key_d      = 1'b0;
                  was_long_d = 1'b0;
                  rel_d      = 1'b1;
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         endcase
      end

      // Per-channel state, counter and output registers.
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            was_long_q <= 1'b0;
            key_q      <= 1'b0;
            press_q    <= 1'b0;
            rel_q      <= 1'b0;
            long_q     <= 1'b0;
            rep_q      <= 1'b0;
         end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            was_long_q <= was_long_d;
            key_q      <= key_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            long_q     <= long_d;
            rep_q      <= rep_d;
         end
      end

      assign key_state[gi]     = key_q;
      assign press_pulse[gi]   = press_q;
      assign release_pulse[gi] = rel_q;
      assign long_pulse[gi]    = long_q;
      assign repeat_pulse[gi]  = rep_q;
   end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: T = 10 cycles, 3 ms debounce, 20 ms long press.
// Instance a repeats every 5 ms, instance b has repeat disabled.
module tb_key_debounce_multi;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [3:0] pin_in = 4'hF;
   logic [3:0] ks_a, press_a, rel_a, long_a, rep_a;
   logic [3:0] ks_b, press_b, rel_b, long_b, rep_b;

   int n_checks = 0;
   int n_fail   = 0;

   int cp_a[4], cr_a[4], cl_a[4], crp_a[4];
   int cp_b[4], cr_b[4], cl_b[4], crp_b[4];
   int all_press = 0;
   int ks0_low   = 0;
   int s_cp_a[4], s_cr_a[4], s_cl_a[4], s_crp_a[4];
   int s_cp_b[4], s_cr_b[4], s_cl_b[4], s_crp_b[4];
   int s_all_press, s_ks0_low;

   typedef struct {
      logic [3:0] pins;
      int         cycles;
      logic [3:0] st;
      logic [3:0] p;
      logic [3:0] r;
      logic [3:0] l;
      logic [3:0] rp;
      logic [3:0] rpb;
   } vec_t;

   vec_t vecs[14];

   always #5 clk = ~clk;

   key_debounce_multi #(
      .N_KEYS(4), .CLK_FREQ_HZ(10000), .DEBOUNCE_MS(3), .LONG_MS(20), .REPEAT_MS(5),
      .ACTIVE_LOW(1'b1)
   ) u_dut_a (
      .clk(clk), .rstn(rstn), .pin_in(pin_in), .key_state(ks_a), .press_pulse(press_a),
      .release_pulse(rel_a), .long_pulse(long_a), .repeat_pulse(rep_a)
   );

   key_debounce_multi #(
      .N_KEYS(4), .CLK_FREQ_HZ(10000), .DEBOUNCE_MS(3), .LONG_MS(20), .REPEAT_MS(0),
      .ACTIVE_LOW(1'b1)
   ) u_dut_b (
      .clk(clk), .rstn(rstn), .pin_in(pin_in), .key_state(ks_b), .press_pulse(press_b),
      .release_pulse(rel_b), .long_pulse(long_b), .repeat_pulse(rep_b)
   );

   // Pulse counters sampled mid-cycle.
   always @(negedge clk) begin
      if (rstn) begin
         for (int c = 0; c < 4; c++) begin
            cp_a[c]  <= cp_a[c] + int'(press_a[c]);
            cr_a[c]  <= cr_a[c] + int'(rel_a[c]);
            cl_a[c]  <= cl_a[c] + int'(long_a[c]);
            crp_a[c] <= crp_a[c] + int'(rep_a[c]);
            cp_b[c]  <= cp_b[c] + int'(press_b[c]);
            cr_b[c]  <= cr_b[c] + int'(rel_b[c]);
            cl_b[c]  <= cl_b[c] + int'(long_b[c]);
            crp_b[c] <= crp_b[c] + int'(rep_b[c]);
         end
         if (press_a == 4'hF) all_press <= all_press + 1;
         if (!ks_a[0]) ks0_low <= ks0_low + 1;
      end
   end

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic check_range(input string name, input int got, input int lo, input int hi);
      n_checks++;
      if (got < lo || got > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic snap();
      s_cp_a = cp_a; s_cr_a = cr_a; s_cl_a = cl_a; s_crp_a = crp_a;
      s_cp_b = cp_b; s_cr_b = cr_b; s_cl_b = cl_b; s_crp_b = crp_b;
      s_all_press = all_press;
      s_ks0_low   = ks0_low;
   endtask

   // Cycles from the current point until a press (kind 0) or release pulse of
   // instance a on channel ch; 100 means it never came.
   task automatic wait_pulse(input int ch, input int kind, output int n);
      n = 0;
      while (n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (kind == 0 ? press_a[ch] : rel_a[ch]) break;
      end
   endtask

   initial begin
      int n;
      // pins, cycles, key_state, press, release, long, repeat(a), repeat(b)
      vecs[0]  = '{4'b1111,  50, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vecs[1]  = '{4'b1110,  60, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vecs[2]  = '{4'b1110, 100, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vecs[3]  = '{4'b1111,  60, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
      vecs[4]  = '{4'b1011,  60, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vecs[5]  = '{4'b1011, 120, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vecs[6]  = '{4'b1011,  50, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
      vecs[7]  = '{4'b1011,  40, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
      vecs[8]  = '{4'b1011,  50, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
      vecs[9]  = '{4'b1011,  50, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
      vecs[10] = '{4'b1011,  10, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vecs[11] = '{4'b1111,  60, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
      vecs[12] = '{4'b0000,  60, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vecs[13] = '{4'b1111,  60, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};

      // Reset state and first cycle after release.
      step(3);
      check("reset outputs a", int'({ks_a, press_a, rel_a, long_a, rep_a}), 0);
      check("reset outputs b", int'({ks_b, press_b, rel_b, long_b, rep_b}), 0);
      rstn = 1'b1;
      step(1);
      check("post-reset outputs a", int'({ks_a, press_a, rel_a, long_a, rep_a}), 0);

      for (int i = 0; i < 14; i++) begin
         pin_in = vecs[i].pins;
         snap();
         step(vecs[i].cycles);
         check($sformatf("v%0d key_state a", i), int'(ks_a), int'(vecs[i].st));
         check($sformatf("v%0d key_state b", i), int'(ks_b), int'(vecs[i].st));
         for (int c = 0; c < 4; c++) begin
            check($sformatf("v%0d press a ch%0d", i, c), cp_a[c] - s_cp_a[c], int'(vecs[i].p[c]));
            check($sformatf("v%0d release a ch%0d", i, c), cr_a[c] - s_cr_a[c],
                  int'(vecs[i].r[c]));
            check($sformatf("v%0d long a ch%0d", i, c), cl_a[c] - s_cl_a[c], int'(vecs[i].l[c]));
            check($sformatf("v%0d repeat a ch%0d", i, c), crp_a[c] - s_crp_a[c],
                  int'(vecs[i].rp[c]));
            check($sformatf("v%0d press b ch%0d", i, c), cp_b[c] - s_cp_b[c], int'(vecs[i].p[c]));
            check($sformatf("v%0d release b ch%0d", i, c), cr_b[c] - s_cr_b[c],
                  int'(vecs[i].r[c]));
            check($sformatf("v%0d long b ch%0d", i, c), cl_b[c] - s_cl_b[c], int'(vecs[i].l[c]));
            check($sformatf("v%0d repeat b ch%0d", i, c), crp_b[c] - s_crp_b[c],
                  int'(vecs[i].rpb[c]));
         end
      end

      // Clean press and release latency on key 0.
      snap();
      pin_in[0] = 1'b0;
      wait_pulse(0, 0, n);
      check_range("clean press latency", n, 23, 33);
      check("clean key_state high", int'(ks_a[0]), 1);
      step(100 - n);
      pin_in[0] = 1'b1;
      wait_pulse(0, 1, n);
      check_range("clean release latency", n, 23, 33);
      step(40);
      check("clean key_state low", int'(ks_a[0]), 0);
      check("clean press count", cp_a[0] - s_cp_a[0], 1);
      check("clean release count", cr_a[0] - s_cr_a[0], 1);

      // Bounce on key 1: 7-cycle toggles never satisfy the debounce window.
      snap();
      for (int k = 0; k < 8; k++) begin
         pin_in[1] = (k % 2 == 0) ? 1'b0 : 1'b1;
         step(7);
      end
      check("bounce no press", cp_a[1] - s_cp_a[1], 0);
      check("bounce no release", cr_a[1] - s_cr_a[1], 0);
      pin_in[1] = 1'b0;
      wait_pulse(1, 0, n);
      check_range("bounce press latency", n, 23, 33);
      step(40);
      check("bounce single press", cp_a[1] - s_cp_a[1], 1);
      pin_in[1] = 1'b1;
      step(60);
      check("bounce key_state low", int'(ks_a[1]), 0);

      // Release glitch on key 0 while held.
      pin_in[0] = 1'b0;
      step(60);
      snap();
      pin_in[0] = 1'b1;
      step(15);
      pin_in[0] = 1'b0;
      step(40);
      check("glitch no release", cr_a[0] - s_cr_a[0], 0);
      check("glitch key_state stayed 1", ks0_low - s_ks0_low, 0);
      check("glitch no long", cl_a[0] - s_cl_a[0], 0);
      pin_in[0] = 1'b1;
      step(60);
      check("glitch later release", cr_a[0] - s_cr_a[0], 1);
      check("glitch key_state low", int'(ks_a[0]), 0);

      // Simultaneous presses land in one cycle.
      snap();
      pin_in = 4'b0000;
      step(60);
      check("simultaneous press cycle", all_press - s_all_press, 1);
      pin_in = 4'b1111;
      step(60);

      // Reset while key 2 is in long-press.
      snap();
      pin_in[2] = 1'b0;
      step(250);
      check("pre-reset key2 long", cl_a[2] - s_cl_a[2], 1);
      check("pre-reset key2 held", int'(ks_a[2]), 1);
      rstn = 1'b0;
      #1;
      check("mid reset outputs a", int'({ks_a, press_a, rel_a, long_a, rep_a}), 0);
      check("mid reset outputs b", int'({ks_b, press_b, rel_b, long_b, rep_b}), 0);
      step(3);
      snap();
      rstn = 1'b1;
      wait_pulse(2, 0, n);
      check_range("re-press after reset", n, 23, 33);
      check("no release across reset", cr_a[2] - s_cr_a[2], 0);
      pin_in[2] = 1'b1;
      step(60);
      check("after reset release", int'(ks_a[2]), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
